// File: rtl/int_pkg.sv
// Shared definitions for the integer datapath blocks: dot-accumulator state
// encoding and the signed min/max constants used when clamping.
package int_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } dot_acc_state_t;

    // Callers truncate the result to w bits.
    function automatic logic [63:0] acc_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/int_sat_add.sv
// Combinational W-bit signed adder with overflow flag.
// Clamps on overflow when INT_DOT_ACC_SATURATE_EN is defined, otherwise wraps.
module int_sat_add
    import int_pkg::*;
#(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W-1:0] raw_sum;

    assign raw_sum = a_i + b_i;
    assign ovf_o   = (a_i[W-1] == b_i[W-1]) && (raw_sum[W-1] != a_i[W-1]);

`ifdef INT_DOT_ACC_SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = W'(acc_max(W));
    localparam logic [W-1:0] SAT_MIN = W'(acc_min(W));

    // Clamp direction follows the (shared) operand sign.
    assign sum_o = ovf_o ? (a_i[W-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    assign sum_o = raw_sum;
`endif

endmodule

// File: rtl/int_dot_acc.sv
// Dot-product accumulator: sums signed product beats into a vector result.
// Optional clamping of the accumulator via INT_DOT_ACC_SATURATE_EN.
module int_dot_acc
    import int_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ACC_WIDTH = 20,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_prod,
    input  logic                 in_ovf,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_ovf
);

    dot_acc_state_t       state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 vec_ovf_q, vec_ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] add_sum;
    logic                 add_ovf;
    logic                 accept;
    logic                 first_beat;
    logic [ACC_WIDTH-1:0] beat_acc;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic                 beat_ovf;

    assign prod_ext = {{(ACC_WIDTH - WIDTH){in_prod[WIDTH-1]}}, in_prod};

    int_sat_add #(
        .W(ACC_WIDTH)
    ) u_add (
        .a_i  (acc_q),
        .b_i  (prod_ext),
        .sum_o(add_sum),
        .ovf_o(add_ovf)
    );

    assign in_ready   = (state_q == HOLD) ? out_ready : 1'b1;
    assign accept     = in_valid & in_ready;
    // A beat accepted outside ACC always opens a new vector (IDLE, or HOLD mid-handshake).
    assign first_beat = (state_q != ACC);

    always_comb begin
        if (first_beat) begin
            beat_acc = prod_ext;
            beat_cnt = CNT_WIDTH'(1);
            beat_ovf = in_ovf;
        end else begin
            beat_acc = add_sum;
            beat_cnt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            beat_ovf = vec_ovf_q | in_ovf | add_ovf;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        vec_ovf_d   = vec_ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE, ACC, HOLD: begin
                if (accept) begin
                    acc_d     = beat_acc;
                    cnt_d     = beat_cnt;
                    vec_ovf_d = beat_ovf;
                    if (in_last) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_sum_d   = beat_acc;
                        out_count_d = beat_cnt;
                        out_ovf_d   = beat_ovf;
                    end else begin
                        state_d     = ACC;
                        out_valid_d = 1'b0;
                    end
                end else if (state_q == HOLD && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            vec_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            vec_ovf_q   <= vec_ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_int_dot_acc.sv
// Directed self-checking bench for int_dot_acc; a second instance with
// ACC_WIDTH=10 exercises accumulator overflow.
module tb_int_dot_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_prod = '0;
    logic        in_ovf = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_ovf;
    logic [19:0] out_sum;
    logic [7:0]  out_count;

    logic        in_ready10, out_valid10, out_ovf10;
    logic [9:0]  out_sum10;
    logic [7:0]  out_count10;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_dot_acc #(.WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    int_dot_acc #(.WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(8)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready10),
        .in_prod(in_prod), .in_ovf(in_ovf), .in_last(in_last),
        .out_valid(out_valid10), .out_ready(out_ready), .out_sum(out_sum10),
        .out_count(out_count10), .out_ovf(out_ovf10)
    );

    // Present one beat in the cycle that starts at the next negedge; leaves
    // in_valid low #1 after the accepting edge, where callers sample.
    task automatic send_beat(input logic [7:0] p, input logic ov, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = p;
        in_ovf   = ov;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_ovf   = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_sum !== 20'd0) begin errors++; $display("FAIL reset_sum got=%0h exp=0", out_sum); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_beat(8'd3, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_mid_valid got=%0b exp=0", out_valid); end
        send_beat(8'hFB, 1'b0, 1'b0);
        send_beat(8'd10, 1'b0, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        checks++; if (out_sum !== 20'd8) begin errors++; $display("FAIL basic_sum got=%0h exp=8", out_sum); end
        checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL basic_count got=%0d exp=3", out_count); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%0b exp=0", out_ovf); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop_valid got=%0b exp=0", out_valid); end
        checks++; if (out_sum !== 20'd8) begin errors++; $display("FAIL basic_hold_sum got=%0h exp=8", out_sum); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        out_ready = 1'b0;
        send_beat(8'h80, 1'b0, 1'b1);
        checks++; if (out_sum !== 20'hFFF80) begin errors++; $display("FAIL hold_sum got=%0h exp=fff80", out_sum); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL hold_count got=%0d exp=1", out_count); end
        // A pending beat during the stall must not be taken.
        in_valid = 1'b1;
        in_prod  = 8'd55;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got=%0b exp=1", i, out_valid); end
            checks++; if (out_sum !== 20'hFFF80) begin errors++; $display("FAIL hold_stable_sum[%0d] got=%0h exp=fff80", i, out_sum); end
            checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL hold_stable_count[%0d] got=%0d exp=1", i, out_count); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got=%0b exp=0", i, in_ready); end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%0b exp=0", out_valid); end
        checks++; if (out_sum !== 20'hFFF80) begin errors++; $display("FAIL hold_release_sum got=%0h exp=fff80", out_sum); end
    endtask

    task automatic test_overflow();
        logic [9:0] exp10;
`ifdef INT_DOT_ACC_SATURATE_EN
        exp10 = 10'h1FF;
`else
        exp10 = 10'h27B;
`endif
        for (int i = 0; i < 5; i++) send_beat(8'd127, 1'b0, (i == 4));
        checks++; if (out_valid10 !== 1'b1) begin errors++; $display("FAIL ovf10_valid got=%0b exp=1", out_valid10); end
        checks++; if (out_sum10 !== exp10) begin errors++; $display("FAIL ovf10_sum got=%0h exp=%0h", out_sum10, exp10); end
        checks++; if (out_ovf10 !== 1'b1) begin errors++; $display("FAIL ovf10_flag got=%0b exp=1", out_ovf10); end
        checks++; if (out_count10 !== 8'd5) begin errors++; $display("FAIL ovf10_count got=%0d exp=5", out_count10); end
        checks++; if (in_ready10 !== 1'b1) begin errors++; $display("FAIL ovf10_in_ready got=%0b exp=1", in_ready10); end
        checks++; if (out_sum !== 20'd635) begin errors++; $display("FAIL ovf20_sum got=%0h exp=27b", out_sum); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL ovf20_flag got=%0b exp=0", out_ovf); end
        idle_cycle();
    endtask

    task automatic test_in_ovf();
        send_beat(8'd2, 1'b1, 1'b0);
        send_beat(8'd4, 1'b0, 1'b1);
        checks++; if (out_sum !== 20'd6) begin errors++; $display("FAIL inovf_sum got=%0h exp=6", out_sum); end
        checks++; if (out_ovf !== 1'b1) begin errors++; $display("FAIL inovf_flag got=%0b exp=1", out_ovf); end
        send_beat(8'd1, 1'b0, 1'b1);
        checks++; if (out_sum !== 20'd1) begin errors++; $display("FAIL inovf_next_sum got=%0h exp=1", out_sum); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL inovf_clear got=%0b exp=0", out_ovf); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        send_beat(8'd1, 1'b0, 1'b0);
        send_beat(8'd2, 1'b0, 1'b1);
        checks++; if (out_sum !== 20'd3) begin errors++; $display("FAIL b2b_a_sum got=%0h exp=3", out_sum); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL b2b_a_count got=%0d exp=2", out_count); end
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = 8'd7;
        in_last  = 1'b1;
        #1;
        checks++; if ((out_valid & in_ready) !== 1'b1) begin errors++; $display("FAIL b2b_handshake got=%0b exp=1", out_valid & in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid got=%0b exp=1", out_valid); end
        checks++; if (out_sum !== 20'd7) begin errors++; $display("FAIL b2b_b_sum got=%0h exp=7", out_sum); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL b2b_b_count got=%0d exp=1", out_count); end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        send_beat(8'd5, 1'b0, 1'b0);
        send_beat(8'd6, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_sum !== 20'd0) begin errors++; $display("FAIL rmid_sum got=%0h exp=0", out_sum); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL rmid_count got=%0d exp=0", out_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        send_beat(8'd9, 1'b0, 1'b1);
        checks++; if (out_sum !== 20'd9) begin errors++; $display("FAIL rmid_after_sum got=%0h exp=9", out_sum); end
        checks++; if (out_count !== 8'd1) begin errors++; $display("FAIL rmid_after_count got=%0d exp=1", out_count); end
        idle_cycle();
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 260; i++) send_beat(8'hFF, 1'b0, (i == 259));
        checks++; if (out_count !== 8'hFF) begin errors++; $display("FAIL cntsat_count got=%0d exp=255", out_count); end
        checks++; if (out_sum !== 20'hFFEFC) begin errors++; $display("FAIL cntsat_sum got=%0h exp=ffefc", out_sum); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_in_ovf();
        test_back_to_back();
        test_reset_mid();
        test_count_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
